fl_ckpt_ctrl: RTL
=================

# fl_ckpt_ctrl

Branch-checkpoint controller for the speculative free list in the rename stage. It allocates a checkpoint per in-flight control instruction and stores the free-list head captured at rename. It retires checkpoints in program order as branches resolve, and on a misprediction it sequences the free-list head restore (`ctrlVerified`/`freeListHeadCp`) and flushes younger checkpoints. It also forwards commit-time exception recovery (`recoverFlag`) and back-pressures rename when checkpoints are exhausted.

## Interface
- `CKPT_DEPTH`, 4: number of checkpoint entries; power of two.
- `CKPT_LOG`, 2: log2(`CKPT_DEPTH`).
- `FL_LOG`, `SIZE_FREE_LIST_LOG`: free-list head pointer width.

- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ckptReq_i` input 1: rename requests a checkpoint for a branch this cycle.
- `headSnap_i` input FL_LOG: free-list head to store with the request.
- `ckptAck_o` output 1: request accepted this cycle (combinational).
- `ckptId_o` output CKPT_LOG: id assigned to an accepted request (= tail index).
- `resolveValid_i` input 1: a branch resolves this cycle.
- `resolveId_i` input CKPT_LOG: id of the resolving branch.
- `mispredict_i` input 1: the resolving branch mispredicted.
- `exception_i` input 1: commit-time full recovery.
- `ctrlVerified_o` output 1: one-cycle restore pulse to the free list.
- `freeListHeadCp_o` output FL_LOG: head to restore, valid with `ctrlVerified_o`.
- `recoverFlag_o` output 1: one-cycle full-recovery pulse to the free list.
- `stall_o` output 1: rename must hold.
- `ckptCnt_o` output CKPT_LOG+1: live checkpoint count.

## Operation
- Storage: circular buffer of `CKPT_DEPTH` entries {valid, resolved, head}.
  - Head and tail pointers are CKPT_LOG+1 bits, with the MSB used as a wrap bit.
  - full = equal indices and differing MSB; empty = pointers equal.
- Allocate: accept when `ckptReq_i` & !full & state==IDLE & !(resolveValid_i & mispredict_i) & !exception_i.
  - On accept: write {1,0,headSnap_i} at tail, then tail++.
  - An unaccepted request is dropped. Rename must retry because `stall_o` is high.
- Correct resolve (`resolveValid_i` & !`mispredict_i`) of a valid id: set `resolved`. Out-of-order resolves are allowed.
- Retire: each cycle, if the oldest entry is valid and resolved, clear it and increment head. At most one retire per cycle.
- Resolves to an invalid id are ignored.
- FSM states: IDLE, RESTORE, SETTLE, FLUSH.
  - IDLE -> RESTORE: on a mispredict of a valid id k. Latch the stored head into `freeListHeadCp_o`, invalidate all entries younger than k, set tail = k+1.
  - RESTORE: `ctrlVerified_o`=1 for exactly one cycle, then go to SETTLE.
  - SETTLE: one cycle with no allocation, then go to IDLE.
  - In RESTORE or SETTLE, a mispredict on a still-valid entry older than k re-enters RESTORE with that entry. All other resolves are applied normally.
  - Any state -> FLUSH on `exception_i`: invalidate all entries, head = tail = 0. FLUSH drives `recoverFlag_o`=1 for one cycle, then goes to IDLE. Exception has priority over mispredict.
- `stall_o` = full | state!=IDLE | exception_i.

## Timing
- Reset value of every output is 0, including `freeListHeadCp_o`. All entries are invalid and the FSM is in IDLE.
- Allocation has zero latency: `ckptAck_o`/`ckptId_o` are combinational in the request cycle, and the entry is written at the next edge.
- Mispredict in cycle N:
  - `ctrlVerified_o` and `freeListHeadCp_o` are asserted in N+1.
  - First allocation is possible in N+3.
- Exception in cycle N: `recoverFlag_o` in N+1, allocation possible in N+2.
- Simultaneous retire and allocate at full: allocation uses the pre-retire full flag, so it is refused.
- Pointer arithmetic wraps modulo 2·`CKPT_DEPTH`. The younger-than test compares ages as (id − head) mod `CKPT_DEPTH`.
- Reset asserted mid-RESTORE: outputs drop to 0 immediately (asynchronous); no pulse completes.

## Configuration
- `FL_CKPT_STATS_EN` defined: adds 16-bit saturating counters `mispredCnt_o` and `fullStallCnt_o`.
  - `mispredCnt_o` counts RESTORE entries.
  - `fullStallCnt_o` counts cycles with `ckptReq_i` & full.
  - Both clear on reset.
- Undefined: the counters and their ports are absent.

## Structure
- Shared package: the FSM state enum, the checkpoint entry struct {valid, resolved, head}, and `CKPT_DEPTH`/`CKPT_LOG` defaults.
- One sub-module, `fl_ckpt_age`: combinational age comparator producing the younger-than mask from head, k, and the valid vector.

## Test plan
- Reset, then 4 requests with heads 3,7,11,15 -> ids 0..3 acked, `ckptCnt_o`=4, 5th request gives `ckptAck_o`=0 and `stall_o`=1.
- Resolve ids 2,1 correct, then 0 correct -> ids 0,1,2 retire on three successive cycles, `ckptCnt_o` goes 4→1.
- Live ids 0..3, mispredict id 1 (head 7) -> next cycle `ctrlVerified_o`=1 with `freeListHeadCp_o`=7; `ckptCnt_o`=2; next allocation gets id 2 two cycles later.
- Mispredict id 2 in the same cycle as a request -> request not acked; restore head is id 2's stored head.
- Exception during RESTORE -> `recoverFlag_o`=1 next cycle, `ckptCnt_o`=0, no further `ctrlVerified_o`.
- Allocate/retire 10 times to wrap the pointers -> the id sequence repeats 0..3 and full/empty flags remain correct.

Source files
------------

// File: rtl/fl_ckpt_ctrl_pkg.sv
// Shared types and sizing for the free-list branch-checkpoint controller.
package fl_ckpt_ctrl_pkg;

    localparam int unsigned CKPT_DEPTH_DEF     = 4;
    localparam int unsigned CKPT_LOG_DEF       = 2;
    localparam int unsigned SIZE_FREE_LIST_LOG = 6;
    localparam int unsigned FL_LOG             = SIZE_FREE_LIST_LOG;
    localparam int unsigned STAT_W             = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        SETTLE  = 2'd2,
        FLUSH   = 2'd3
    } ckptState_e;

    typedef struct packed {
        logic              valid;
        logic              resolved;
        logic [FL_LOG-1:0] head;
    } ckptEntry_t;

endpackage

// File: rtl/fl_ckpt_ctrl_if.sv
// Rename/branch-unit facing bundle of the checkpoint controller.
// FL_CKPT_STATS_EN adds the misprediction and full-stall counters.
interface fl_ckpt_ctrl_if
    import fl_ckpt_ctrl_pkg::*;
#(
    parameter int unsigned CKPT_LOG = CKPT_LOG_DEF
) ();

    logic                ckptReq_i;
    logic [FL_LOG-1:0]   headSnap_i;
    logic                ckptAck_o;
    logic [CKPT_LOG-1:0] ckptId_o;
    logic                resolveValid_i;
    logic [CKPT_LOG-1:0] resolveId_i;
    logic                mispredict_i;
    logic                exception_i;
    logic                ctrlVerified_o;
    logic [FL_LOG-1:0]   freeListHeadCp_o;
    logic                recoverFlag_o;
    logic                stall_o;
    logic [CKPT_LOG:0]   ckptCnt_o;

`ifdef FL_CKPT_STATS_EN
    logic [STAT_W-1:0]   mispredCnt_o;
    logic [STAT_W-1:0]   fullStallCnt_o;

    modport master (
        output ckptReq_i, headSnap_i, resolveValid_i, resolveId_i, mispredict_i, exception_i,
        input  ckptAck_o, ckptId_o, ctrlVerified_o, freeListHeadCp_o, recoverFlag_o,
               stall_o, ckptCnt_o, mispredCnt_o, fullStallCnt_o
    );
    modport slave (
        input  ckptReq_i, headSnap_i, resolveValid_i, resolveId_i, mispredict_i, exception_i,
        output ckptAck_o, ckptId_o, ctrlVerified_o, freeListHeadCp_o, recoverFlag_o,
               stall_o, ckptCnt_o, mispredCnt_o, fullStallCnt_o
    );
`else
    modport master (
        output ckptReq_i, headSnap_i, resolveValid_i, resolveId_i, mispredict_i, exception_i,
        input  ckptAck_o, ckptId_o, ctrlVerified_o, freeListHeadCp_o, recoverFlag_o,
               stall_o, ckptCnt_o
    );
    modport slave (
        input  ckptReq_i, headSnap_i, resolveValid_i, resolveId_i, mispredict_i, exception_i,
        output ckptAck_o, ckptId_o, ctrlVerified_o, freeListHeadCp_o, recoverFlag_o,
               stall_o, ckptCnt_o
    );
`endif

endinterface

// File: rtl/fl_ckpt_age.sv
// Marks valid checkpoints strictly younger than entry k, ages taken relative to head.
module fl_ckpt_age #(
    parameter int unsigned CKPT_DEPTH = 4,
    parameter int unsigned CKPT_LOG   = 2
) (
    input  logic [CKPT_LOG-1:0]   headIdx,
    input  logic [CKPT_LOG-1:0]   k,
    input  logic [CKPT_DEPTH-1:0] validVec,
    output logic [CKPT_DEPTH-1:0] youngerMask
);

    logic [CKPT_LOG-1:0] kAge;
    logic [CKPT_LOG-1:0] entryAge;

    always_comb begin
        kAge        = k - headIdx;
        entryAge    = '0;
        youngerMask = '0;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            entryAge       = CKPT_LOG'(i) - headIdx;
            youngerMask[i] = validVec[i] && (entryAge > kAge);
        end
    end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// Branch-checkpoint controller for the speculative free-list head in rename.
// FL_CKPT_STATS_EN adds saturating misprediction / full-stall counters.
module fl_ckpt_ctrl
    import fl_ckpt_ctrl_pkg::*;
#(
    parameter int unsigned CKPT_DEPTH = CKPT_DEPTH_DEF,
    parameter int unsigned CKPT_LOG   = CKPT_LOG_DEF
) (
    input  logic           clk,
    input  logic           reset,
    fl_ckpt_ctrl_if.slave  ckptIf
);

    localparam int unsigned PTR_W = CKPT_LOG + 1;

    ckptState_e            state, nextState;
    ckptEntry_t            entries [CKPT_DEPTH];
    logic [PTR_W-1:0]      headPtr, tailPtr, kPtr, nextHead, nextTail;
    logic [CKPT_LOG-1:0]   headIdx, tailIdx, restoreId, resAge, kAge;
    logic [CKPT_DEPTH-1:0] validVec, youngerMask;
    logic                  full, misp, idValid, olderThanK, retireGo, allocGo, resolveOk, restoreGo;

    // Buffer status and per-cycle decisions
    always_comb begin
        headIdx    = headPtr[CKPT_LOG-1:0];
        tailIdx    = tailPtr[CKPT_LOG-1:0];
        full       = (headIdx == tailIdx) && (headPtr[CKPT_LOG] != tailPtr[CKPT_LOG]);
        for (int i = 0; i < CKPT_DEPTH; i++) validVec[i] = entries[i].valid;
        idValid    = entries[ckptIf.resolveId_i].valid;
        misp       = ckptIf.resolveValid_i && ckptIf.mispredict_i;
        resolveOk  = ckptIf.resolveValid_i && !ckptIf.mispredict_i && idValid;
        resAge     = ckptIf.resolveId_i - headIdx;
        kAge       = restoreId - headIdx;
        olderThanK = resAge < kAge;
        retireGo   = entries[headIdx].valid && entries[headIdx].resolved;
        allocGo    = ckptIf.ckptReq_i && !full && (state == IDLE) && !misp && !ckptIf.exception_i;
    end

    fl_ckpt_age #(.CKPT_DEPTH(CKPT_DEPTH), .CKPT_LOG(CKPT_LOG)) u_age (
        .headIdx     (headIdx),
        .k           (ckptIf.resolveId_i),
        .validVec    (validVec),
        .youngerMask (youngerMask)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next state; exception outranks any mispredict
    always_comb begin
        nextState = state;
        restoreGo = 1'b0;
        if (ckptIf.exception_i) begin
            nextState = FLUSH;
        end else begin
            case (state)
                IDLE: begin
                    if (misp && idValid) begin
                        restoreGo = 1'b1;
                        nextState = RESTORE;
                    end
                end
                RESTORE, SETTLE: begin
                    if (misp && idValid && olderThanK) begin
                        restoreGo = 1'b1;
                        nextState = RESTORE;
                    end else begin
                        nextState = (state == RESTORE) ? SETTLE : IDLE;
                    end
                end
                FLUSH:   nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Restore cuts the tail to k+1 using the full wrap-bit pointer of k
    always_comb begin
        kPtr     = headPtr + PTR_W'(resAge);
        nextHead = headPtr + PTR_W'(retireGo);
        nextTail = restoreGo ? (kPtr + PTR_W'(1)) : (tailPtr + PTR_W'(allocGo));
    end

    assign ckptIf.ckptAck_o = allocGo;
    assign ckptIf.ckptId_o  = tailIdx;
    assign ckptIf.stall_o   = full || (state != IDLE) || ckptIf.exception_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr                 <= '0;
            tailPtr                 <= '0;
            restoreId               <= '0;
            ckptIf.ctrlVerified_o   <= 1'b0;
            ckptIf.freeListHeadCp_o <= '0;
            ckptIf.recoverFlag_o    <= 1'b0;
            ckptIf.ckptCnt_o        <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) entries[i] <= '0;
        end else begin
            ckptIf.ctrlVerified_o <= restoreGo;
            ckptIf.recoverFlag_o  <= ckptIf.exception_i;
            if (ckptIf.exception_i) begin
                headPtr          <= '0;
                tailPtr          <= '0;
                ckptIf.ckptCnt_o <= '0;
                for (int i = 0; i < CKPT_DEPTH; i++) entries[i] <= '0;
            end else begin
                headPtr          <= nextHead;
                tailPtr          <= nextTail;
                ckptIf.ckptCnt_o <= nextTail - nextHead;
                if (resolveOk) entries[ckptIf.resolveId_i].resolved <= 1'b1;
                if (retireGo) begin
                    entries[headIdx].valid    <= 1'b0;
                    entries[headIdx].resolved <= 1'b0;
                end
                if (restoreGo) begin
                    restoreId               <= ckptIf.resolveId_i;
                    ckptIf.freeListHeadCp_o <= entries[ckptIf.resolveId_i].head;
                    for (int i = 0; i < CKPT_DEPTH; i++) begin
                        if (youngerMask[i]) entries[i] <= '0;
                    end
                end
                if (allocGo) begin
                    entries[tailIdx] <= '{valid: 1'b1, resolved: 1'b0, head: ckptIf.headSnap_i};
                end
            end
        end
    end

`ifdef FL_CKPT_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ckptIf.mispredCnt_o   <= '0;
            ckptIf.fullStallCnt_o <= '0;
        end else begin
            if (restoreGo && (ckptIf.mispredCnt_o != '1))
                ckptIf.mispredCnt_o <= ckptIf.mispredCnt_o + STAT_W'(1);
            if (ckptIf.ckptReq_i && full && (ckptIf.fullStallCnt_o != '1))
                ckptIf.fullStallCnt_o <= ckptIf.fullStallCnt_o + STAT_W'(1);
        end
    end
`else
`endif

endmodule
